// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants, fetch mode encoding and PC helpers
package mips_pkg;

    localparam int          WORD_W           = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_HOLD  = 2'd1,
        MODE_FLUSH = 2'd2
    } fetch_mode_e;

    // Branch/jump targets are byte addresses; fetch is word aligned.
    function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
        return addr & ~(WORD_W'(3));
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - control inputs and IF/ID outputs of the fetch stage
interface fetch_stage_if;
    import mips_pkg::*;

    logic              stall_i;
    logic              redirect_i;
    logic [WORD_W-1:0] redirect_pc_i;
    logic [WORD_W-1:0] pc_o;
    logic [WORD_W-1:0] if_id_instr_o;
    logic [WORD_W-1:0] if_id_pc4_o;
    logic              if_id_valid_o;
    logic [WORD_W-1:0] fetch_count_o;

    modport master (
        input  stall_i, redirect_i, redirect_pc_i,
        output pc_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o, fetch_count_o
    );

    modport slave (
        output stall_i, redirect_i, redirect_pc_i,
        input  pc_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o, fetch_count_o
    );

endinterface

// File: rtl/instr_mem.sv
// rtl/instr_mem.sv - combinational instruction ROM, NOP outside its depth
module instr_mem
    import mips_pkg::*;
#(
    parameter int          IMEM_WORDS = 64,
    parameter string       INIT_FILE  = "instructions.txt",
    parameter logic [WORD_W-1:0] INIT_WORDS [IMEM_WORDS] = '{default: NOP_INSTR}
) (
    input  logic [WORD_W-3:0] i_word_addr,
    output logic [WORD_W-1:0] o_instr
);

    localparam int                AW       = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam logic [WORD_W-3:0] DEPTH    = (WORD_W-2)'(IMEM_WORDS);
    // An empty image name means an unprogrammed ROM that reads as NOPs.
    localparam bit                HAS_IMAGE = (INIT_FILE != "");
    localparam logic [WORD_W-1:0] ROM [IMEM_WORDS] = INIT_WORDS;

    logic          w_in_range;
    logic [AW-1:0] w_idx;

    assign w_in_range = (i_word_addr < DEPTH);
    assign w_idx      = i_word_addr[AW-1:0];

    always_comb begin
        o_instr = NOP_INSTR;
        if (w_in_range && HAS_IMAGE) begin
            o_instr = ROM[w_idx];
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, ROM fetch and IF/ID register with stall/redirect
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int                IMEM_WORDS = 64,
    parameter string             INIT_FILE  = "instructions.txt",
    parameter logic [WORD_W-1:0] INIT_WORDS [IMEM_WORDS] = '{default: NOP_INSTR}
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] r_instr;
    logic [WORD_W-1:0] r_pc4;
    logic              r_valid;
    logic [WORD_W-1:0] r_count;

    logic [WORD_W-1:0] w_instr;
    logic [WORD_W-1:0] w_pc4;
    logic [WORD_W-1:0] w_target;
    fetch_mode_e       w_mode;

    instr_mem #(
        .IMEM_WORDS (IMEM_WORDS),
        .INIT_FILE  (INIT_FILE),
        .INIT_WORDS (INIT_WORDS)
    ) u_imem (
        .i_word_addr (r_pc[WORD_W-1:2]),
        .o_instr     (w_instr)
    );

    assign w_pc4    = r_pc + PC_INC;
    assign w_target = align_word(bus.redirect_pc_i);

    // A redirect squashes the slot being fetched, so it outranks a stall.
    always_comb begin
        w_mode = MODE_RUN;
        if (bus.redirect_i) begin
            w_mode = MODE_FLUSH;
        end else if (bus.stall_i) begin
            w_mode = MODE_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
            r_pc4   <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
        end else begin
            case (w_mode)
                MODE_FLUSH: begin
                    r_pc    <= w_target;
                    r_instr <= NOP_INSTR;
                    r_pc4   <= '0;
                    r_valid <= 1'b0;
                end
                MODE_HOLD: begin
                end
                default: begin
                    r_pc    <= w_pc4;
                    r_instr <= w_instr;
                    r_pc4   <= w_pc4;
                    r_valid <= 1'b1;
                    r_count <= r_count + 1'b1;
                end
            endcase
        end
    end

    assign bus.pc_o          = r_pc;
    assign bus.if_id_instr_o = r_instr;
    assign bus.if_id_pc4_o   = r_pc4;
    assign bus.if_id_valid_o = r_valid;
    assign bus.fetch_count_o = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;
    import mips_pkg::*;

    localparam int          DEPTH  = 64;
    localparam logic [31:0] ROM_IMG [DEPTH] = '{
        0: 32'h2010_0005, 1: 32'h2011_0003, 2: 32'h0211_9020, 3: 32'h0000_0000,
        4: 32'h1111_0004, 5: 32'h1111_0005, 8: 32'h8C13_0008, 16: 32'h2222_0010,
        default: 32'hA5A5_0000
    };

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] count;
    } exp_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    exp_t m;
    exp_t sb [$];

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC   (32'h0),
        .IMEM_WORDS (DEPTH),
        .INIT_FILE  ("instructions.txt"),
        .INIT_WORDS (ROM_IMG)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        logic [31:0] idx;
        idx = pc >> 2;
        return (idx < DEPTH) ? ROM_IMG[idx[5:0]] : 32'h0;
    endfunction

    task automatic step(input string tag, input logic rst, input logic st,
                        input logic rd, input logic [31:0] tgt);
        exp_t e;
        @(negedge clk);
        reset             = rst;
        bus.stall_i       = st;
        bus.redirect_i    = rd;
        bus.redirect_pc_i = tgt;
        if (rst) begin
            m = '{pc: 32'h0, instr: 32'h0, pc4: 32'h0, valid: 1'b0, count: 32'h0};
        end else if (rd) begin
            m.pc    = {tgt[31:2], 2'b00};
            m.instr = 32'h0;
            m.pc4   = 32'h0;
            m.valid = 1'b0;
        end else if (!st) begin
            m.instr = rom_word(m.pc);
            m.pc4   = m.pc + 32'd4;
            m.valid = 1'b1;
            m.count = m.count + 32'd1;
            m.pc    = m.pc + 32'd4;
        end
        sb.push_back(m);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_val({tag, ".pc"},    bus.pc_o,                 e.pc);
        check_val({tag, ".instr"}, bus.if_id_instr_o,        e.instr);
        check_val({tag, ".pc4"},   bus.if_id_pc4_o,          e.pc4);
        check_val({tag, ".valid"}, {31'h0, bus.if_id_valid_o}, {31'h0, e.valid});
        check_val({tag, ".count"}, bus.fetch_count_o,        e.count);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m = '0;
        reset = 1'b1;
        bus.stall_i = 1'b0;
        bus.redirect_i = 1'b0;
        bus.redirect_pc_i = 32'h0;

        step("rst", 1, 0, 0, 32'h0);
        step("rst", 1, 0, 0, 32'h0);
        check_val("rst_pc_const", bus.pc_o, 32'h0);

        for (int i = 0; i < 4; i++) step("run", 0, 0, 0, 32'h0);
        check_val("run_pc_const",    bus.pc_o, 32'h10);
        check_val("run_cnt_const",   bus.fetch_count_o, 32'd4);
        check_val("run_instr_const", bus.if_id_instr_o, 32'h0);

        step("rst2", 1, 0, 0, 32'h0);
        step("run2", 0, 0, 0, 32'h0);
        step("run2", 0, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) step("stall", 0, 1, 0, 32'h0);
        check_val("stall_pc_const",    bus.pc_o, 32'h8);
        check_val("stall_instr_const", bus.if_id_instr_o, 32'h2011_0003);
        step("post_stall", 0, 0, 0, 32'h0);
        check_val("post_stall_instr_const", bus.if_id_instr_o, 32'h0211_9020);
        check_val("post_stall_pc4_const",   bus.if_id_pc4_o, 32'hC);

        step("redir", 0, 0, 1, 32'h0000_0021);
        check_val("redir_pc_const",  bus.pc_o, 32'h20);
        check_val("redir_cnt_const", bus.fetch_count_o, 32'd3);
        step("post_redir", 0, 0, 0, 32'h0);
        check_val("post_redir_instr_const", bus.if_id_instr_o, 32'h8C13_0008);
        check_val("post_redir_pc4_const",   bus.if_id_pc4_o, 32'h24);

        step("redir_stall", 0, 1, 1, 32'h40);
        check_val("redir_stall_pc_const", bus.pc_o, 32'h40);

        step("oob_redir", 0, 0, 1, 32'h100);
        step("oob", 0, 0, 0, 32'h0);
        check_val("oob_pc4_const", bus.if_id_pc4_o, 32'h104);

        step("wrap_redir", 0, 0, 1, 32'hFFFF_FFFF);
        step("wrap", 0, 0, 0, 32'h0);
        check_val("wrap_pc_const", bus.pc_o, 32'h0);

        step("rst3", 1, 0, 0, 32'h0);
        for (int i = 0; i < 5; i++) step("run3", 0, 0, 0, 32'h0);
        step("stall3", 0, 1, 0, 32'h0);
        check_val("stall3_pc_const", bus.pc_o, 32'h14);
        step("rst_in_stall", 1, 1, 0, 32'h0);
        step("resume", 0, 0, 0, 32'h0);
        check_val("resume_instr_const", bus.if_id_instr_o, 32'h2010_0005);

        for (int i = 0; i < 60; i++) begin
            step("rand", 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 5) == 0), 32'($urandom_range(0, 300)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
